// File: rtl/return_button_tracker_pkg.sv
// -----------------------------------------------------------------------------
// return_button_tracker_pkg
//   Shared definitions for the on-screen UI buttons: the RETURN button
//   rectangle defaults, the coordinate width, the 3-bit button FSM state
//   encoding and small edge-detect helpers. The game-over pixel generator and
//   the sudoku-screen buttons import the same package so their state decoding
//   agrees with the tracker.
// -----------------------------------------------------------------------------
package return_button_tracker_pkg;

  localparam int DEF_COORD_W = 10;

  // RETURN button rectangle, all edges inclusive
  localparam int DEF_BTN_X0 = 270;
  localparam int DEF_BTN_X1 = 369;
  localparam int DEF_BTN_Y0 = 300;
  localparam int DEF_BTN_Y1 = 339;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOVER   = 3'd1,
    ST_PRESSED = 3'd2,
    ST_DRAGOUT = 3'd3,
    ST_CLICKED = 3'd4
  } btn_state_t;

  // Rising edge of the registered button level
  function automatic logic btn_press(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  // Falling edge of the registered button level
  function automatic logic btn_release(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/rect_hit.sv
// -----------------------------------------------------------------------------
// rect_hit
//   Combinational point-in-rectangle test. All four edges are inclusive and
//   the comparisons are unsigned at COORD_W bits. Reused by every on-screen
//   button with its own X0/X1/Y0/Y1.
//
// Ports
//   i_x    in   COORD_W  point column
//   i_y    in   COORD_W  point row
//   o_hit  out  1        1 when (i_x, i_y) lies inside the rectangle
// -----------------------------------------------------------------------------
module rect_hit
  import return_button_tracker_pkg::*;
#(
  parameter int                 COORD_W = DEF_COORD_W,
  parameter logic [COORD_W-1:0] X0      = COORD_W'(DEF_BTN_X0),
  parameter logic [COORD_W-1:0] X1      = COORD_W'(DEF_BTN_X1),
  parameter logic [COORD_W-1:0] Y0      = COORD_W'(DEF_BTN_Y0),
  parameter logic [COORD_W-1:0] Y1      = COORD_W'(DEF_BTN_Y1)
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_hit
);

  logic w_in_x;
  logic w_in_y;

  assign w_in_x = (i_x >= X0) && (i_x <= X1);
  assign w_in_y = (i_y >= Y0) && (i_y <= Y1);
  assign o_hit  = w_in_x && w_in_y;

endmodule

// File: rtl/return_button_tracker.sv
// -----------------------------------------------------------------------------
// return_button_tracker
//   Tracks the mouse against the RETURN button on the game-over screen.
//   Produces frame-synchronous hover/press flags that select the button colour
//   in the pixel generator, and a one-cycle click pulse for the game FSM.
//   A click needs both the press and the release inside the rectangle.
//
// Ports
//   clk                     in   1        system clock
//   rst                     in   1        synchronous, active-high reset
//   mouse_x                 in   COORD_W  pointer column
//   mouse_y                 in   COORD_W  pointer row
//   MOUSE_LEFT              in   1        left button level, 1 = held
//   frame_start             in   1        1-cycle pulse at start of vblank
//   enable                  in   1        1 while the game-over screen is shown
//   mouse_on_return_button  out  1        hover flag, updated only on frame_start
//   return_pressed          out  1        press flag, updated only on frame_start
//   return_click            out  1        1-cycle click pulse
// -----------------------------------------------------------------------------
module return_button_tracker
  import return_button_tracker_pkg::*;
#(
  parameter int                 COORD_W = DEF_COORD_W,
  parameter logic [COORD_W-1:0] BTN_X0  = COORD_W'(DEF_BTN_X0),
  parameter logic [COORD_W-1:0] BTN_X1  = COORD_W'(DEF_BTN_X1),
  parameter logic [COORD_W-1:0] BTN_Y0  = COORD_W'(DEF_BTN_Y0),
  parameter logic [COORD_W-1:0] BTN_Y1  = COORD_W'(DEF_BTN_Y1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] mouse_x,
  input  logic [COORD_W-1:0] mouse_y,
  input  logic               MOUSE_LEFT,
  input  logic               frame_start,
  input  logic               enable,
  output logic               mouse_on_return_button,
  output logic               return_pressed,
  output logic               return_click
);

  logic [COORD_W-1:0] r_x_p0;
  logic [COORD_W-1:0] r_y_p0;
  logic               r_left_p0;
  logic               r_left_p1;

  logic               w_inside;
  logic               w_press;
  logic               w_release;

  btn_state_t         r_state;
  btn_state_t         w_state_nxt;

  logic               w_hover_nxt;
  logic               w_press_nxt;
  logic               w_click;

  logic               r_hover;
  logic               r_pressed;

  // ---- stage p0: input registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_p0    <= '0;
      r_y_p0    <= '0;
      r_left_p0 <= 1'b0;
      r_left_p1 <= 1'b0;
    end else begin
      r_x_p0    <= mouse_x;
      r_y_p0    <= mouse_y;
      r_left_p0 <= MOUSE_LEFT;
      r_left_p1 <= r_left_p0;
    end
  end

  rect_hit #(
    .COORD_W (COORD_W),
    .X0      (BTN_X0),
    .X1      (BTN_X1),
    .Y0      (BTN_Y0),
    .Y1      (BTN_Y1)
  ) u_hit (
    .i_x   (r_x_p0),
    .i_y   (r_y_p0),
    .o_hit (w_inside)
  );

  assign w_press   = btn_press(r_left_p0, r_left_p1);
  assign w_release = btn_release(r_left_p0, r_left_p1);

  // ---- stage p1: button FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        // A held button never qualifies here, so a press that started
        // outside cannot turn into a hover until it is released.
        ST_IDLE: begin
          if (w_inside && !r_left_p0) w_state_nxt = ST_HOVER;
        end
        ST_HOVER: begin
          if (!w_inside)             w_state_nxt = ST_IDLE;
          else if (w_press)          w_state_nxt = ST_PRESSED;
        end
        // Release is judged against the same registered position, so a
        // release coinciding with an exit gives no click.
        ST_PRESSED: begin
          if (w_release)             w_state_nxt = w_inside ? ST_CLICKED : ST_IDLE;
          else if (!w_inside)        w_state_nxt = ST_DRAGOUT;
        end
        ST_DRAGOUT: begin
          if (w_release)             w_state_nxt = ST_IDLE;
          else if (w_inside)         w_state_nxt = ST_PRESSED;
        end
        ST_CLICKED: begin
          w_state_nxt = w_inside ? ST_HOVER : ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_hover_nxt = 1'b0;
    w_press_nxt = 1'b0;
    w_click     = 1'b0;
    if (enable) begin
      w_hover_nxt = (r_state != ST_IDLE) && (r_state != ST_DRAGOUT);
      w_press_nxt = (r_state == ST_PRESSED);
      w_click     = (r_state == ST_CLICKED);
    end
  end

  // ---- stage p2: frame-synchronous display flags ----
  // Colour flags only move during vblank so a button never changes colour
  // part-way down the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hover   <= 1'b0;
      r_pressed <= 1'b0;
    end else if (frame_start) begin
      r_hover   <= w_hover_nxt;
      r_pressed <= w_press_nxt;
    end
  end

  assign mouse_on_return_button = r_hover;
  assign return_pressed         = r_pressed;
  assign return_click           = w_click;

endmodule

// File: tb/tb_return_button_tracker.sv
module tb_return_button_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       MOUSE_LEFT;
  logic       frame_start;
  logic       enable;
  logic       mouse_on_return_button;
  logic       return_pressed;
  logic       return_click;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  return_button_tracker dut (
    .clk                    (clk),
    .rst                    (rst),
    .mouse_x                (mouse_x),
    .mouse_y                (mouse_y),
    .MOUSE_LEFT             (MOUSE_LEFT),
    .frame_start            (frame_start),
    .enable                 (enable),
    .mouse_on_return_button (mouse_on_return_button),
    .return_pressed         (return_pressed),
    .return_click           (return_click)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic move(input int x, input int y);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  int   bx  [5] = '{270, 369, 269, 370, 300};
  int   by  [5] = '{300, 339, 300, 339, 340};
  logic bin [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; enable = 1'b1; frame_start = 1'b1; MOUSE_LEFT = 1'b1;
    move(300, 320);

    // 1: reset with pointer inside and button held
    tick(3);
    chk("rst_hover", mouse_on_return_button, 1'b0);
    chk("rst_pressed", return_pressed, 1'b0);
    chk("rst_click", return_click, 1'b0);
    rst = 1'b0; frame_start = 1'b0;
    tick(3);
    frame();
    chk("held_after_rst_idle", mouse_on_return_button, 1'b0);
    MOUSE_LEFT = 1'b0;
    tick(2);
    frame();
    chk("hover_after_release", mouse_on_return_button, 1'b1);
    chk("hover_not_pressed", return_pressed, 1'b0);

    // 2: clean click
    MOUSE_LEFT = 1'b1;
    tick(2);
    frame();
    chk("hold_pressed", return_pressed, 1'b1);
    chk("hold_hover", mouse_on_return_button, 1'b1);
    tick(2);
    MOUSE_LEFT = 1'b0;
    tick(1);
    chk("click_lat1", return_click, 1'b0);
    tick(1);
    chk("click_lat2", return_click, 1'b1);
    tick(1);
    chk("click_single", return_click, 1'b0);
    frame();
    chk("after_click_pressed", return_pressed, 1'b0);
    chk("after_click_hover", mouse_on_return_button, 1'b1);

    // 3a: drag out and release outside
    MOUSE_LEFT = 1'b1;
    tick(2);
    move(100, 100);
    tick(2);
    frame();
    chk("dragout_hover", mouse_on_return_button, 1'b0);
    chk("dragout_pressed", return_pressed, 1'b0);
    MOUSE_LEFT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("dragout_noclick", return_click, 1'b0);
    end

    // 3b: drag out and back in before release
    move(300, 320);
    tick(2);
    MOUSE_LEFT = 1'b1;
    tick(2);
    move(100, 100);
    tick(2);
    move(300, 320);
    tick(2);
    MOUSE_LEFT = 1'b0;
    tick(1);
    chk("dragback_lat1", return_click, 1'b0);
    tick(1);
    chk("dragback_click", return_click, 1'b1);
    tick(1);
    chk("dragback_single", return_click, 1'b0);

    // 4: press outside, slide in, release
    move(100, 100);
    tick(2);
    MOUSE_LEFT = 1'b1;
    tick(2);
    move(300, 320);
    tick(3);
    frame();
    chk("slidein_no_hover", mouse_on_return_button, 1'b0);
    MOUSE_LEFT = 1'b0;
    tick(1);
    chk("slidein_noclick1", return_click, 1'b0);
    tick(1);
    chk("slidein_noclick2", return_click, 1'b0);
    frame();
    chk("slidein_hover_after_rel", mouse_on_return_button, 1'b1);

    // 5: rectangle boundaries
    for (int i = 0; i < 5; i++) begin
      move(bx[i], by[i]);
      tick(3);
      frame();
      chk($sformatf("bound_%0d_%0d", bx[i], by[i]), mouse_on_return_button, bin[i]);
    end

    // 6: frame synchronisation
    move(300, 320);
    tick(3);
    chk("midframe_hold0", mouse_on_return_button, 1'b0);
    frame();
    chk("frame_hover1", mouse_on_return_button, 1'b1);
    move(100, 100);
    tick(3);
    chk("midframe_hold1", mouse_on_return_button, 1'b1);
    frame();
    chk("frame_hover0", mouse_on_return_button, 1'b0);

    // 6b: disabled screen suppresses the click
    move(300, 320);
    tick(3);
    enable = 1'b0;
    tick(1);
    MOUSE_LEFT = 1'b1;
    tick(3);
    MOUSE_LEFT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("disabled_noclick", return_click, 1'b0);
    end
    frame();
    chk("disabled_hover_clear", mouse_on_return_button, 1'b0);
    enable = 1'b1;
    tick(3);
    frame();
    chk("reenabled_hover", mouse_on_return_button, 1'b1);

    // reset in the middle of a press
    MOUSE_LEFT = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    MOUSE_LEFT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rst_midpress_noclick", return_click, 1'b0);
    end
    frame();
    chk("rst_midpress_hover_back", mouse_on_return_button, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
